// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA scan-out stage for a 12-bit (4:4:4) colour path.
// It generates raster timing from the system clock using a CLK_DIV tick divider. It requests
// active pixels by coordinate and samples the returned colour RD_LAT ticks later. The active,
// sync and border flags are delayed so they stay aligned with that colour.
//
// Optional feature: define VGA_BORDER_EN to force the outermost active ring to 0xFFF.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   rgb_in       colour {R,G,B} for the pixel requested RD_LAT ticks earlier
//   pix_req      one-clk pulse when (pix_x,pix_y) is a newly requested active pixel
//   pix_x/pix_y  requested coordinate; holds the last active value during blanking
//   vga_r/g/b    registered colour, zero outside the active area
//   hsync/vsync  active-low syncs, aligned with the colour
//   frame_start  one-clk pulse on the tick at raster position (0,0)
module vga_scan_out #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb_in,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0] DivLast  = 3'(CLK_DIV - 1);
    localparam logic [9:0] HLast    = 10'(HTotal - 1);
    localparam logic [9:0] VLast    = 10'(VTotal - 1);
    localparam logic [9:0] HAct     = 10'(H_ACTIVE);
    localparam logic [9:0] VAct     = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [2:0]  div_q, div_d;
    logic        tick;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic        active_now, hs_now, vs_now;

    logic        pix_req_q, pix_req_d, fs_q, fs_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;

    // Stage 0 is aligned with the request registers; stage RD_LAT is aligned with rgb_in.
    logic [RD_LAT:0] act_pipe_q, act_pipe_d;
    logic [RD_LAT:0] hs_pipe_q, hs_pipe_d;
    logic [RD_LAT:0] vs_pipe_q, vs_pipe_d;

    logic [11:0] rgb_q, rgb_d, colour_src;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;

    // Divider and raster counters
    always_comb begin
        tick  = (div_q == DivLast);
        div_d = tick ? 3'd0 : div_q + 3'd1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == HLast) begin
                h_d = 10'd0;
                v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_comb begin
        active_now = (h_q < HAct) && (v_q < VAct);
        hs_now     = !((h_q >= HSyncBeg) && (h_q < HSyncEnd));
        vs_now     = !((v_q >= VSyncBeg) && (v_q < VSyncEnd));
    end

    // Request stage: pulses last one clk because they are cleared on non-tick clocks.
    always_comb begin
        pix_req_d = tick && active_now;
        fs_d      = tick && (h_q == 10'd0) && (v_q == 10'd0);
        pix_x_d   = pix_req_d ? h_q : pix_x_q;
        pix_y_d   = pix_req_d ? v_q : pix_y_q;
    end

    always_comb begin
        act_pipe_d = act_pipe_q;
        hs_pipe_d  = hs_pipe_q;
        vs_pipe_d  = vs_pipe_q;
        if (tick) begin
            act_pipe_d[0] = active_now;
            hs_pipe_d[0]  = hs_now;
            vs_pipe_d[0]  = vs_now;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                act_pipe_d[i] = act_pipe_q[i-1];
                hs_pipe_d[i]  = hs_pipe_q[i-1];
                vs_pipe_d[i]  = vs_pipe_q[i-1];
            end
        end
    end

`ifdef VGA_BORDER_EN
    logic            border_now;
    logic [RD_LAT:0] bd_pipe_q, bd_pipe_d;

    always_comb begin
        border_now = (h_q == 10'd0) || (h_q == HAct - 10'd1) ||
                     (v_q == 10'd0) || (v_q == VAct - 10'd1);
        bd_pipe_d  = bd_pipe_q;
        if (tick) begin
            bd_pipe_d[0] = border_now;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                bd_pipe_d[i] = bd_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) bd_pipe_q <= '0;
        else        bd_pipe_q <= bd_pipe_d;
    end

    assign colour_src = bd_pipe_q[RD_LAT] ? 12'hFFF : rgb_in;
`else
    assign colour_src = rgb_in;
`endif

    // Output register: rgb_in is only looked at on a tick.
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (tick) begin
            rgb_d   = act_pipe_q[RD_LAT] ? colour_src : 12'h000;
            hsync_d = hs_pipe_q[RD_LAT];
            vsync_d = vs_pipe_q[RD_LAT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= 3'd0;
            h_q        <= 10'd0;
            v_q        <= 10'd0;
            pix_req_q  <= 1'b0;
            fs_q       <= 1'b0;
            pix_x_q    <= 10'd0;
            pix_y_q    <= 10'd0;
            act_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            rgb_q      <= 12'h000;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            div_q      <= div_d;
            h_q        <= h_d;
            v_q        <= v_d;
            pix_req_q  <= pix_req_d;
            fs_q       <= fs_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            act_pipe_q <= act_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign pix_req     = pix_req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = fs_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a shrunken raster (15x10 total, 8x6 active) so whole frames fit.
module tb_vga_scan_out;

    localparam int CD  = 4;
    localparam int RL  = 1;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;
`ifdef VGA_BORDER_EN
    localparam bit Border = 1'b1;
`else
    localparam bit Border = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] rgb_in;
    logic        pix_req, hsync, vsync, frame_start;
    logic [9:0]  pix_x, pix_y;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [35:0] obs;

    int          cyc;
    int          n_cmp, n_err;
    bit          src_on, src_zero, chk_on;
    logic [11:0] fb [HA*VA];

    vga_scan_out #(
        .CLK_DIV(CD), .RD_LAT(RL),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    assign obs = {pix_req, pix_x, pix_y, vga_r, vga_g, vga_b, hsync, vsync, frame_start};

    // Clock edges since the last edge that saw reset asserted.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] bsel(input logic [11:0] v);
        return Border ? 12'hFFF : v;
    endfunction

    function automatic bit is_active(input int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    // Colour the connector should show for raster position p.
    function automatic logic [11:0] pix_colour(input int p);
        int h, v;
        h = p % HT;
        v = p / HT;
        if (h >= HA || v >= VA) return 12'h000;
        if (Border && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)) return 12'hFFF;
        return fb[v*HA + h];
    endfunction

    // Expected outputs after c edges out of reset. Tick k lands on edge CD*(k+1) and requests
    // raster position k mod FR; the output shown after tick k belongs to request k-RL-1.
    function automatic logic [35:0] model(input int c);
        logic       req, hs, vs, fs;
        logic [9:0] x, y;
        logic [11:0] rgb;
        int k, n, h, v, j, p;
        req = 0; hs = 1; vs = 1; fs = 0; x = 0; y = 0; rgb = 0;
        if (c >= CD) begin
            k = c / CD - 1;
            n = k % FR;
            h = n % HT;
            v = n / HT;
            if (c % CD == 0) begin
                req = is_active(n);
                fs  = (n == 0);
            end
            if (v < VA) begin
                x = 10'((h < HA) ? h : HA - 1);
                y = 10'(v);
            end else begin
                x = 10'(HA - 1);
                y = 10'(VA - 1);
            end
            j = k - RL - 1;
            if (j >= 0) begin
                p   = j % FR;
                rgb = pix_colour(p);
                hs  = !((p % HT) >= HA + HFP && (p % HT) < HA + HFP + HS);
                vs  = !((p / HT) >= VA + VFP && (p / HT) < VA + VFP + VS);
            end
        end
        return {req, x, y, rgb, hs, vs, fs};
    endfunction

    // Checker, then frame source. The source puts valid data on rgb_in only for the edge that
    // samples it and drives noise (or 0xFFF during blanking) otherwise.
    always @(negedge clk) begin
        int cn, k, j;
        if (chk_on) check("model", obs, model(cyc));
        if (src_zero) begin
            rgb_in = 12'h000;
        end else if (src_on) begin
            cn = cyc + 1;
            if (cn % CD == 0) begin
                k = cn / CD - 1;
                j = k - RL - 1;
                if (j >= 0 && is_active(j % FR))
                    rgb_in = fb[((j % FR) / HT) * HA + (j % FR) % HT];
                else
                    rgb_in = 12'hFFF;
            end else begin
                rgb_in = 12'($urandom);
            end
        end
    end

    task automatic wait_c(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (cyc == target) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic reset_dut(input int clocks);
        rst_n = 1'b0;
        repeat (clocks) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          k;
        logic        req;
        logic [9:0]  x, y;
        logic [11:0] rgb;
        logic        hs, vs, fs;
    } vec_t;

    typedef struct {
        int          n;
        logic [11:0] rgb;
    } bvec_t;

    initial begin
        vec_t  tbl [14];
        bvec_t btbl [5];
        bit    ok;
        int    cnt, first_req, hf0, hf1, hr0, vf0, vr0, fs0t, fs1t, reqs;
        logic  phs, pvs;

        rst_n = 1'b0; rgb_in = 12'hFFF;
        src_on = 0; src_zero = 0; chk_on = 0; n_cmp = 0; n_err = 0;
        for (int v = 0; v < VA; v++)
            for (int h = 0; h < HA; h++)
                fb[v*HA + h] = {4'(v), 8'(h)};

        // Reset hold with rgb_in = 0xFFF: colour stays black, syncs idle high
        repeat (10) begin
            @(negedge clk);
            check("reset_hold", 36'({vga_r, vga_g, vga_b, hsync, vsync}), 36'({12'h000, 2'b11}));
        end
        src_on = 1;
        rst_n  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (pix_req) break;
        end
        check("first_req_clks", 36'(cnt), 36'(CD));
        check("first_req_xy_fs", 36'({pix_x, pix_y, frame_start}), 36'({10'd0, 10'd0, 1'b1}));

        // Checkpoints on tick k: req, x, y, rgb, hs, vs, fs
        tbl[0]  = '{0,   1, 0, 0, 12'h000,          1, 1, 1};
        tbl[1]  = '{7,   1, 7, 0, bsel(12'h005),    1, 1, 0};
        tbl[2]  = '{8,   0, 7, 0, bsel(12'h006),    1, 1, 0};
        tbl[3]  = '{12,  0, 7, 0, 12'h000,          0, 1, 0};
        tbl[4]  = '{14,  0, 7, 0, 12'h000,          0, 1, 0};
        tbl[5]  = '{15,  1, 0, 1, 12'h000,          1, 1, 0};
        tbl[6]  = '{19,  1, 4, 1, 12'h102,          1, 1, 0};
        tbl[7]  = '{38,  0, 7, 2, 12'h206,          1, 1, 0};
        tbl[8]  = '{39,  0, 7, 2, bsel(12'h207),    1, 1, 0};
        tbl[9]  = '{107, 0, 7, 5, 12'h000,          1, 0, 0};
        tbl[10] = '{136, 0, 7, 5, 12'h000,          1, 0, 0};
        tbl[11] = '{137, 0, 7, 5, 12'h000,          1, 1, 0};
        tbl[12] = '{147, 0, 7, 5, 12'h000,          0, 1, 0};
        tbl[13] = '{150, 1, 0, 0, 12'h000,          1, 1, 1};
        for (int i = 0; i < 14; i++) begin
            wait_c(CD * (tbl[i].k + 1), ok);
            if (!ok) check($sformatf("tbl%0d_timeout", i), 36'(cyc), 36'(CD * (tbl[i].k + 1)));
            else check($sformatf("tbl_k%0d", tbl[i].k), obs,
                       {tbl[i].req, tbl[i].x, tbl[i].y, tbl[i].rgb,
                        tbl[i].hs, tbl[i].vs, tbl[i].fs});
        end

        // Timing measurements over one frame plus a little
        reset_dut(1);
        first_req = -1; hf0 = -1; hf1 = -1; hr0 = -1; vf0 = -1; vr0 = -1;
        fs0t = -1; fs1t = -1; reqs = 0; phs = 1; pvs = 1;
        for (int t = 1; t <= 700; t++) begin
            @(negedge clk);
            if (pix_req && first_req < 0) first_req = t;
            if (pix_req && hf0 >= 0 && hf1 < 0) reqs++;
            if (phs && !hsync) begin
                if (hf0 < 0) hf0 = t;
                else if (hf1 < 0) hf1 = t;
            end
            if (!phs && hsync && hr0 < 0) hr0 = t;
            if (pvs && !vsync && vf0 < 0) vf0 = t;
            if (!pvs && vsync && vr0 < 0) vr0 = t;
            if (frame_start) begin
                if (fs0t < 0) fs0t = t;
                else if (fs1t < 0) fs1t = t;
            end
            phs = hsync;
            pvs = vsync;
        end
        check("meas_first_req", 36'(first_req), 36'(CD));
        check("meas_hs_fall", 36'(hf0 - first_req), 36'((HA + HFP + RL + 1) * CD));
        check("meas_hs_low", 36'(hr0 - hf0), 36'(HS * CD));
        check("meas_line", 36'(hf1 - hf0), 36'(HT * CD));
        check("meas_req_per_line", 36'(reqs), 36'(HA));
        check("meas_vs_fall", 36'(vf0 - first_req), 36'(((VA + VFP) * HT + RL + 1) * CD));
        check("meas_vs_low", 36'(vr0 - vf0), 36'(VS * HT * CD));
        check("meas_frame", 36'(fs1t - fs0t), 36'(FR * CD));

        // One-clock reset in mid-frame at position (4,3)
        reset_dut(1);
        wait_c(CD * (3 * HT + 4 + 1), ok);
        check("midrst_reach", 36'(ok), 36'(1));
        check("midrst_before", 36'({pix_x, pix_y}), 36'({10'd4, 10'd3}));
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_vals", obs, {1'b0, 10'd0, 10'd0, 12'h000, 1'b1, 1'b1, 1'b0});
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (frame_start) break;
        end
        check("midrst_fs_clks", 36'(cnt), 36'(CD));
        check("midrst_fs_xy", 36'({pix_x, pix_y, pix_req}), 36'({10'd0, 10'd0, 1'b1}));

        // Border pixels with a black source
        src_zero = 1;
        reset_dut(1);
        btbl[0] = '{0 * HT + 2, bsel(12'h000)};
        btbl[1] = '{2 * HT + 0, bsel(12'h000)};
        btbl[2] = '{2 * HT + 2, 12'h000};
        btbl[3] = '{2 * HT + 7, bsel(12'h000)};
        btbl[4] = '{5 * HT + 2, bsel(12'h000)};
        for (int i = 0; i < 5; i++) begin
            wait_c(CD * (btbl[i].n + RL + 2), ok);
            if (!ok) check($sformatf("border%0d_timeout", i), 36'(cyc), 36'(CD * (btbl[i].n + RL + 2)));
            else check($sformatf("border_h%0d_v%0d", btbl[i].n % HT, btbl[i].n / HT),
                       36'({vga_r, vga_g, vga_b}), 36'(btbl[i].rgb));
        end
        src_zero = 0;

        // Random frame contents and random resets against the model, every clock
        for (int i = 0; i < HA*VA; i++) fb[i] = 12'($urandom);
        rst_n = 1'b0;
        @(negedge clk);
        chk_on = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            repeat ($urandom_range(300, 1500)) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            for (int i = 0; i < HA*VA; i++) fb[i] = 12'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (700) @(negedge clk);
        chk_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
